// File: rtl/zap_multiply_result_collector.sv
// zap_multiply_result_collector: pairs multiply result halves, derives N/Z/Q flags, queues register writes
module zap_multiply_result_collector #(
  parameter int PHY_REGS   = 46,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_clear_from_writeback,
  input  logic                        i_data_stall,
  input  logic                        i_res_valid,
  input  logic [31:0]                 i_res_data,
  input  logic                        i_res_higher,
  input  logic                        i_res_long,
  input  logic                        i_res_nozero,
  input  logic                        i_res_sat,
  input  logic                        i_res_flag_upd,
  input  logic [$clog2(PHY_REGS)-1:0] i_res_dest,
  input  logic                        i_q_clear,
  input  logic                        i_wb_ready,
  output logic                        o_wb_valid,
  output logic [$clog2(PHY_REGS)-1:0] o_wb_index,
  output logic [31:0]                 o_wb_data,
  output logic                        o_flags_valid,
  output logic                        o_n,
  output logic                        o_z,
  output logic                        o_q,
  output logic                        o_full,
  output logic                        o_seq_err
);
  localparam int IW = $clog2(PHY_REGS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {IDLE, HAVE_LO} state_t;
  state_t            state_q, state_d;
  logic [IW+31:0]    mem_q [FIFO_DEPTH];
  logic [IW+31:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              lo_nz_q, lo_nz_d, seq_err_q, seq_err_d, q_q, q_d;
  logic              fv_q, fv_d, n_q, n_d, z_q, z_d;
  logic              cap, pop, zero, lo_half, hi_zero;
  assign o_wb_valid    = cnt_q != '0;
  assign o_full        = (cnt_q == CW'(FIFO_DEPTH)) & ~(o_wb_valid & i_wb_ready);
  assign pop           = o_wb_valid & i_wb_ready & ~i_clear_from_writeback;
  assign cap           = i_res_valid & ~i_data_stall & ~i_clear_from_writeback & ~o_full;
  assign {o_wb_index, o_wb_data} = o_wb_valid ? mem_q[rd_q] : '0;
  assign zero          = i_res_data == '0;
  assign lo_half       = i_res_long & ~i_res_higher;
  // a pending low half only affects Z when this pulse belongs to a long op
  assign hi_zero       = zero & ~(i_res_long & (i_res_nozero | lo_nz_q));
  assign o_flags_valid = fv_q;
  assign o_n           = n_q;
  assign o_z           = z_q;
  assign o_q           = q_q;
  assign o_seq_err     = seq_err_q;
  // write queue: flush empties it, otherwise push on capture and pop on handshake
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (i_clear_from_writeback) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (cap) mem_d[wr_q] = {i_res_dest, i_res_data};
      wr_d  = cap ? wr_q + 1'b1 : wr_q;
      rd_d  = pop ? rd_q + 1'b1 : rd_q;
      cnt_d = cnt_q + CW'(cap) - CW'(pop);
    end
  end
  // half pairing, flag derivation and sticky Q / sequence error
  always_comb begin
    state_d   = state_q;
    lo_nz_d   = lo_nz_q;
    seq_err_d = seq_err_q;
    fv_d      = 1'b0;
    n_d       = n_q;
    z_d       = z_q;
    q_d       = (cap & i_res_sat) ? 1'b1 : i_q_clear ? 1'b0 : q_q;
    if (i_clear_from_writeback) begin
      state_d = IDLE;
      lo_nz_d = 1'b0;
    end else if (cap & lo_half) begin
      state_d   = HAVE_LO;
      lo_nz_d   = ~zero;
      seq_err_d = seq_err_q | (state_q == HAVE_LO);
    end else if (cap) begin
      state_d   = IDLE;
      lo_nz_d   = 1'b0;
      seq_err_d = seq_err_q | ((state_q == HAVE_LO) & ~i_res_long);
      fv_d      = i_res_flag_upd;
      n_d       = i_res_flag_upd ? i_res_data[31] : n_q;
      z_d       = i_res_flag_upd ? hi_zero : z_q;
    end
  end
  // queue storage needs no reset: outputs are gated by the occupancy count
  always_ff @(posedge i_clk) mem_q <= mem_d;
  // control and flag registers
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      lo_nz_q   <= 1'b0;
      seq_err_q <= 1'b0;
      q_q       <= 1'b0;
      fv_q      <= 1'b0;
      n_q       <= 1'b0;
      z_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      lo_nz_q   <= lo_nz_d;
      seq_err_q <= seq_err_d;
      q_q       <= q_d;
      fv_q      <= fv_d;
      n_q       <= n_d;
      z_q       <= z_d;
    end
  end
endmodule
